// File: rtl/gpio_bus_arbiter.sv
// gpio_bus_arbiter: round-robin two-master GPIO access sequencer (mX_req/wr/addr/wdata in, mX_ack/err/rdata out; CS_N/RD_N/WR_N/Addr/WData out, RData in; busy out)
module gpio_bus_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] MAX_ADDR = 12'h018
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              CS_N,
  output logic              RD_N,
  output logic              WR_N,
  output logic [ADDR_W-1:0] Addr,
  output logic [DATA_W-1:0] WData,
  input  logic [DATA_W-1:0] RData,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state_q, state_d;
  logic last_q, last_d, owner_q, owner_d, wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic cs_n_q, cs_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d, busy_q, busy_d;
  logic [1:0] ack_q, ack_d, err_q, err_d;
  logic [1:0][DATA_W-1:0] rdata_q, rdata_d;
  logic gnt, sel_wr, sel_ok;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  always_comb begin
    gnt = m1_req & (~m0_req | ~last_q);
    sel_wr = gnt ? m1_wr : m0_wr;
    sel_addr = gnt ? m1_addr : m0_addr;
    sel_wdata = gnt ? m1_wdata : m0_wdata;
    sel_ok = sel_addr <= MAX_ADDR && sel_addr[1:0] == 2'b00;
    state_d = state_q;
    last_d = last_q;
    owner_d = owner_q;
    wr_d = wr_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    cs_n_d = 1'b1;
    rd_n_d = 1'b1;
    wr_n_d = 1'b1;
    ack_d = 2'b00;
    err_d = err_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (m0_req | m1_req) begin
        last_d = gnt;
        owner_d = gnt;
        wr_d = sel_wr;
        if (sel_ok) begin
          state_d = ACCESS;
          addr_d = sel_addr;
          wdata_d = sel_wdata;
          cs_n_d = 1'b0;
          rd_n_d = sel_wr;
          wr_n_d = ~sel_wr;
        end else begin
          state_d = DONE;
          ack_d[gnt] = 1'b1;
          err_d[gnt] = 1'b1;
          rdata_d[gnt] = '0;
        end
      end
      ACCESS: begin
        state_d = DONE;
        ack_d[owner_q] = 1'b1;
        err_d[owner_q] = 1'b0;
        rdata_d[owner_q] = wr_q ? rdata_q[owner_q] : RData;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      owner_q <= 1'b0;
      wr_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      cs_n_q <= 1'b1;
      rd_n_q <= 1'b1;
      wr_n_q <= 1'b1;
      busy_q <= 1'b0;
      ack_q <= 2'b00;
      err_q <= 2'b00;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      owner_q <= owner_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      cs_n_q <= cs_n_d;
      rd_n_q <= rd_n_d;
      wr_n_q <= wr_n_d;
      busy_q <= busy_d;
      ack_q <= ack_d;
      err_q <= err_d;
      rdata_q <= rdata_d;
    end
  end
  assign CS_N = cs_n_q;
  assign RD_N = rd_n_q;
  assign WR_N = wr_n_q;
  assign Addr = addr_q;
  assign WData = wdata_q;
  assign busy = busy_q;
  assign m0_ack = ack_q[0];
  assign m1_ack = ack_q[1];
  assign m0_err = err_q[0];
  assign m1_err = err_q[1];
  assign m0_rdata = rdata_q[0];
  assign m1_rdata = rdata_q[1];
endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// tb_gpio_bus_arbiter: directed vector bench for gpio_bus_arbiter
module tb_gpio_bus_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic m0_req = 1'b0, m0_wr = 1'b0, m1_req = 1'b0, m1_wr = 1'b0;
  logic [11:0] m0_addr = '0, m1_addr = '0;
  logic [31:0] m0_wdata = '0, m1_wdata = '0;
  logic m0_ack, m0_err, m1_ack, m1_err, CS_N, RD_N, WR_N, busy;
  logic [31:0] m0_rdata, m1_rdata, WData, RData;
  logic [11:0] Addr;
  logic [31:0] rd_val = '0;
  int total = 0;
  int bad = 0;
  logic [31:0] exp_rd [2];
  typedef struct {
    logic m;
    logic wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdv;
    logic err;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t vecs [8];

  gpio_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .CS_N(CS_N), .RD_N(RD_N), .WR_N(WR_N), .Addr(Addr), .WData(WData),
    .RData(RData), .busy(busy)
  );

  always #5 clk = ~clk;
  // GPIO model: returns data only while a read strobe is active, 0 otherwise
  always_comb RData = (!CS_N && !RD_N) ? rd_val : 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v);
    int strobes = 0;
    int ack_at = -1;
    logic own_ack, own_err, oth_ack;
    logic [31:0] own_rd, oth_rd;
    @(posedge clk); #1;
    rd_val = v.rdv;
    if (v.m) begin
      m1_req = 1'b1; m1_wr = v.wr; m1_addr = v.addr; m1_wdata = v.wdata;
    end else begin
      m0_req = 1'b1; m0_wr = v.wr; m0_addr = v.addr; m0_wdata = v.wdata;
    end
    for (int c = 0; c < 6 && ack_at < 0; c++) begin
      @(negedge clk);
      own_ack = v.m ? m1_ack : m0_ack;
      own_err = v.m ? m1_err : m0_err;
      own_rd = v.m ? m1_rdata : m0_rdata;
      oth_ack = v.m ? m0_ack : m1_ack;
      oth_rd = v.m ? m0_rdata : m1_rdata;
      chk("other_ack", 32'(oth_ack), 32'h0);
      if (!CS_N) begin
        strobes++;
        chk("strobe_cycle", 32'(c), 32'd1);
        chk("addr", 32'(Addr), 32'(v.addr));
        chk("rd_n", 32'(RD_N), 32'(v.wr));
        chk("wr_n", 32'(WR_N), 32'(!v.wr));
        chk("busy", 32'(busy), 32'h1);
        if (v.wr) chk("wdata", WData, v.wdata);
      end
      if (own_ack) begin
        ack_at = c;
        chk("err", 32'(own_err), 32'(v.err));
        chk("rdata", own_rd, v.exp_rd);
        chk("other_rdata", oth_rd, exp_rd[int'(!v.m)]);
        if (v.m) m1_req = 1'b0; else m0_req = 1'b0;
      end
    end
    chk("ack_cycle", 32'(ack_at), v.err ? 32'd1 : 32'd2);
    chk("strobe_count", 32'(strobes), v.err ? 32'd0 : 32'd1);
    exp_rd[int'(v.m)] = v.exp_rd;
    m0_req = 1'b0;
    m1_req = 1'b0;
  endtask

  initial begin
    int evs[$];
    int exp_evs[4];
    logic prev_strobe;
    exp_evs[0] = 4; exp_evs[1] = 11; exp_evs[2] = 16; exp_evs[3] = 23;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    vecs[0] = '{1'b0, 1'b1, 12'h008, 32'h155, 32'h0, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 12'h01A, 32'h0, 32'h99, 1'b1, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 12'h018, 32'h0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF};
    vecs[3] = '{1'b0, 1'b0, 12'h01C, 32'h0, 32'h55, 1'b1, 32'h0};
    vecs[4] = '{1'b0, 1'b0, 12'h004, 32'h0, 32'h12345678, 1'b0, 32'h12345678};
    vecs[5] = '{1'b0, 1'b0, 12'h006, 32'h0, 32'h55, 1'b1, 32'h0};
    vecs[6] = '{1'b1, 1'b1, 12'h014, 32'hA5A5, 32'h0, 1'b0, 32'h0};
    vecs[7] = '{1'b1, 1'b0, 12'h000, 32'h0, 32'h6, 1'b0, 32'h6};
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_cs_n", 32'(CS_N), 32'h1);
    chk("rst_rd_n", 32'(RD_N), 32'h1);
    chk("rst_wr_n", 32'(WR_N), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_acks", 32'({m0_ack, m1_ack, m0_err, m1_err}), 32'h0);
    chk("rst_m0_rdata", m0_rdata, 32'h0);
    chk("rst_m1_rdata", m1_rdata, 32'h0);
    for (int i = 0; i < 8; i++) run_txn(vecs[i]);
    repeat (10) @(negedge clk);
    chk("hold_m1_rdata", m1_rdata, 32'h6);
    chk("hold_m1_ack", 32'(m1_ack), 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 12'h000;
    m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 12'h004;
    rd_val = 32'hA;
    @(posedge clk); #1;
    reset = 1'b0;
    prev_strobe = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (!CS_N && prev_strobe) chk("adjacent_strobe", 32'(c), 32'hFFFF);
      prev_strobe = !CS_N;
      if (m0_ack) evs.push_back(c * 2);
      if (m1_ack) evs.push_back(c * 2 + 1);
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    chk("rr_ack_count", 32'(evs.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("rr_ack_event", i < evs.size() ? 32'(evs[i]) : 32'hFFFF, 32'(exp_evs[i]));
    chk("rr_m0_rdata", m0_rdata, 32'hA);
    chk("rr_m1_rdata", m1_rdata, 32'hA);
    @(posedge clk); #1;
    m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 12'h00C; m1_wdata = 32'h33;
    @(negedge clk);
    @(negedge clk);
    chk("rst_acc_strobe", 32'({CS_N, WR_N}), 32'h0);
    reset = 1'b1;
    @(negedge clk);
    m1_req = 1'b0;
    chk("rst_acc_strobes_high", 32'({CS_N, RD_N, WR_N}), 32'h7);
    chk("rst_acc_no_ack", 32'(m1_ack), 32'h0);
    chk("rst_acc_busy", 32'(busy), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_acc_no_late_ack", 32'({m0_ack, m1_ack}), 32'h0);
    chk("rst_acc_idle", 32'({busy, CS_N}), 32'h1);
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    run_txn('{1'b1, 1'b0, 12'h010, 32'h0, 32'h77, 1'b0, 32'h77});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
